uart_tx_mmio: RTL



---
 rtl/uart_tx_mmio_if.sv | 12 +
 rtl/uart_tx_mmio.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio_if.sv
// CPU-side register bus for the UART transmitter: address, write strobe and
// data, plus the combinational read-back path.
`timescale 1ns/1ps
interface uart_tx_mmio_if;
    logic [15:0] address;
    logic        write_en;
    logic [7:0]  data_in;
    logic [7:0]  data_out;

    modport master (output address, write_en, data_in, input data_out);
    modport slave  (input address, write_en, data_in, output data_out);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: 4-byte register window, TX FIFO and an
// 8N1-style serializer with a programmable bit period.
`timescale 1ns/1ps
module uart_tx_mmio #(
    parameter logic [15:0] BASE_ADDR  = 16'hf010,
    parameter int          FIFO_DEPTH = 8,
    parameter int          DATA_BITS  = 8,
    parameter logic [7:0]  CLK_DIV    = 8'd4
) (
    input  logic             clock,
    input  logic             reset,
    uart_tx_mmio_if.slave    bus,
    output logic             tx,
    output logic             tx_strobe,
    output logic [7:0]       tx_char,
    output logic             irq
);
    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0] DMASK   = 8'hff >> (8 - DATA_BITS);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      bdiv_q, bdiv_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            strobe_q, strobe_d;
    logic [7:0]      char_q, char_d;
    logic [7:0]      div_q, div_d;
    logic            ovf_q, ovf_d;
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]     count_q, count_d;
    logic [7:0]      fifo_mem [FIFO_DEPTH];

    logic       in_win, wr_data, wr_stat, wr_div;
    logic       fifo_empty, fifo_full, busy, pop, push_ok, load, bit_end;
    logic [7:0] div_eff, head;

    assign in_win  = (bus.address[15:2] == BASE_ADDR[15:2]);
    assign wr_data = bus.write_en && in_win && (bus.address[1:0] == 2'd0);
    assign wr_stat = bus.write_en && in_win && (bus.address[1:0] == 2'd1);
    assign wr_div  = bus.write_en && in_win && (bus.address[1:0] == 2'd2);

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign busy       = (state_q != IDLE);
    assign div_eff    = (div_q == 8'd0) ? 8'd1 : div_q;
    assign head       = fifo_mem[rptr_q];
    // bdiv_q holds the period latched at the start of the current bit, so a
    // DIV write only affects the following bit boundary.
    assign bit_end    = (cnt_q == bdiv_q - 8'd1);

    always_comb begin
        bus.data_out = 8'h00;
        if (!bus.write_en && in_win) begin
            unique case (bus.address[1:0])
                2'd1:    bus.data_out = {4'b0, ovf_q, fifo_empty, fifo_full, busy};
                2'd2:    bus.data_out = div_q;
                default: bus.data_out = 8'h00;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bdiv_d    = bdiv_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        strobe_d  = 1'b0;
        char_d    = char_q;
        load      = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                load = !fifo_empty;
            end
            START: begin
                cnt_d = cnt_q + 8'd1;
                if (bit_end) begin
                    cnt_d     = 8'd0;
                    bdiv_d    = div_eff;
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                end
            end
            DATA: begin
                cnt_d = cnt_q + 8'd1;
                if (bit_end) begin
                    cnt_d  = 8'd0;
                    bdiv_d = div_eff;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end
            STOP: begin
                cnt_d = cnt_q + 8'd1;
                if (bit_end) begin
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Frame start is shared by IDLE and the no-gap STOP->START path.
        if (load) begin
            state_d  = START;
            cnt_d    = 8'd0;
            bdiv_d   = div_eff;
            tx_d     = 1'b0;
            shift_d  = head;
            strobe_d = 1'b1;
            char_d   = head;
        end
    end

    assign pop = load;

    always_comb begin
        push_ok = wr_data && (!fifo_full || pop);
        wptr_d  = wptr_q + AW'(push_ok);
        rptr_d  = rptr_q + AW'(pop);
        count_d = count_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Set after clear so a dropped push wins over a same-cycle clear.
        ovf_d = ovf_q;
        if (wr_stat && bus.data_in[3]) ovf_d = 1'b0;
        if (wr_data && fifo_full && !pop) ovf_d = 1'b1;
        div_d = wr_div ? bus.data_in : div_q;
    end

    always_ff @(posedge clock) begin
        if (push_ok) fifo_mem[wptr_q] <= bus.data_in & DMASK;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            bdiv_q    <= 8'd1;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            strobe_q  <= 1'b0;
            char_q    <= 8'd0;
            div_q     <= CLK_DIV;
            ovf_q     <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bdiv_q    <= bdiv_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            strobe_q  <= strobe_d;
            char_q    <= char_d;
            div_q     <= div_d;
            ovf_q     <= ovf_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
        end
    end

    assign tx        = tx_q;
    assign tx_strobe = strobe_q;
    assign tx_char   = char_q;
    assign irq       = fifo_empty && !busy;
endmodule
